// File: rtl/pulse_pkg.sv
// Shared types for the pulse delay meter: measurement FSM states.
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    WAIT_FALL = 2'd2
  } pdm_state_e;

endpackage

// File: rtl/pulse_delay_meter_if.sv
// Pulse inputs, timeout setting and measurement results of the pulse delay meter.
interface pulse_delay_meter_if #(
  parameter int CNT_W = 32
);
  logic             pulse_ref;
  logic             pulse_dly;
  logic [CNT_W-1:0] timeout_num;
  logic             busy;
  logic             meas_valid;
  logic [CNT_W-1:0] meas_delay;
  logic [CNT_W-1:0] meas_width;
  logic             meas_timeout;

  modport master (
    output pulse_ref, pulse_dly, timeout_num,
    input  busy, meas_valid, meas_delay, meas_width, meas_timeout
  );

  modport slave (
    input  pulse_ref, pulse_dly, timeout_num,
    output busy, meas_valid, meas_delay, meas_width, meas_timeout
  );
endinterface

// File: rtl/pulse_edge_det.sv
// Two-flop sampler with rise/fall detect; resets to "high" so a level already
// high when reset releases is not reported as a rising edge.
module pulse_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic [1:0] r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r <= 2'b11;
    else        r <= {r[0], sig};
  end

  assign rise = (r == 2'b01);
  assign fall = (r == 2'b10);

endmodule

// File: rtl/pulse_delay_meter.sv
// Measures ref-rise to dly-rise delay and dly high width, one result per
// reference pulse, with an optional timeout.
module pulse_delay_meter
  import pulse_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  pulse_delay_meter_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic ref_rise, ref_fall, dly_rise, dly_fall;

  pulse_edge_det u_ref_det (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (bus.pulse_ref),
    .rise  (ref_rise),
    .fall  (ref_fall)
  );

  pulse_edge_det u_dly_det (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (bus.pulse_dly),
    .rise  (dly_rise),
    .fall  (dly_fall)
  );

  pdm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] to_q, to_d;
  logic [CNT_W-1:0] dq_q, dq_d;
  logic             issue;
  logic [CNT_W-1:0] res_delay, res_width;
  logic             res_tmo;
  logic             expired;
  logic             valid_q, tmo_q;
  logic [CNT_W-1:0] delay_q, width_q;

  assign expired = (to_q != '0) && (cnt_q == to_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    dq_d      = dq_q;
    issue     = 1'b0;
    res_delay = delay_q;
    res_width = width_q;
    res_tmo   = tmo_q;
    case (state_q)
      IDLE: begin
        if (ref_rise) begin
          to_d  = bus.timeout_num;
          cnt_d = CNT_ONE;
          if (dly_rise) begin
            dq_d    = '0;
            state_d = WAIT_FALL;
          end else begin
            state_d = WAIT_RISE;
          end
        end
      end
      WAIT_RISE: begin
        if (dly_rise) begin
          dq_d    = cnt_q;
          cnt_d   = CNT_ONE;
          state_d = WAIT_FALL;
        end else if (expired) begin
          issue     = 1'b1;
          res_delay = cnt_q;
          res_width = '0;
          res_tmo   = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      WAIT_FALL: begin
        if (dly_fall || expired) begin
          issue     = 1'b1;
          res_delay = dq_q;
          res_width = cnt_q;
          res_tmo   = !dly_fall;
          state_d   = IDLE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: state_d = IDLE;
    endcase
    // A reference edge coinciding with a result starts the next measurement.
    if (issue && ref_rise) begin
      state_d = WAIT_RISE;
      cnt_d   = CNT_ONE;
      to_d    = bus.timeout_num;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      delay_q <= '0;
      width_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= issue;
      if (issue) begin
        delay_q <= res_delay;
        width_q <= res_width;
        tmo_q   <= res_tmo;
      end
    end
  end

  // Timeout and captured delay are only read after being loaded.
  always_ff @(posedge clk) begin
    to_q <= to_d;
    dq_q <= dq_d;
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.meas_valid   = valid_q;
  assign bus.meas_delay   = delay_q;
  assign bus.meas_width   = width_q;
  assign bus.meas_timeout = tmo_q;

  logic unused_ok;
  assign unused_ok = ref_fall;

endmodule

// File: tb/tb_pulse_delay_meter.sv
// Directed bench for pulse_delay_meter: 32-bit and 8-bit instances share stimulus
// and are checked every cycle against an index-based reference model.
module tb_pulse_delay_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ref_in = 1'b0;
  logic        dly_in = 1'b0;
  logic [31:0] tnum = 32'd0;

  always #5 clk = ~clk;

  pulse_delay_meter_if #(.CNT_W(32)) b32 ();
  pulse_delay_meter_if #(.CNT_W(8))  b8  ();

  assign b32.pulse_ref   = ref_in;
  assign b32.pulse_dly   = dly_in;
  assign b32.timeout_num = tnum;
  assign b8.pulse_ref    = ref_in;
  assign b8.pulse_dly    = dly_in;
  assign b8.timeout_num  = tnum[7:0];

  pulse_delay_meter #(.CNT_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  pulse_delay_meter #(.CNT_W(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

  logic        d_busy [2];
  logic        d_valid[2];
  logic [31:0] d_delay[2];
  logic [31:0] d_width[2];
  logic        d_tmo  [2];

  assign d_busy[0]  = b32.busy;
  assign d_valid[0] = b32.meas_valid;
  assign d_delay[0] = b32.meas_delay;
  assign d_width[0] = b32.meas_width;
  assign d_tmo[0]   = b32.meas_timeout;
  assign d_busy[1]  = b8.busy;
  assign d_valid[1] = b8.meas_valid;
  assign d_delay[1] = {24'd0, b8.meas_delay};
  assign d_width[1] = {24'd0, b8.meas_width};
  assign d_tmo[1]   = b8.meas_timeout;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: each measurement is described by the sample indices of
  // the reference edge and the delayed edge; counts are index differences,
  // clipped at the counter maximum.
  longint cmax[2] = '{64'hFFFF_FFFF, 64'hFF};
  int     phase[2];
  longint k_ref[2], k_dly[2], to_l[2], dly_val[2];
  logic   e_valid[2], e_tmo[2];
  longint e_delay[2], e_width[2];
  logic   pr, pd, s_ref, s_dly, have;
  longint k;

  function automatic longint clip(input longint x, input int d);
    return (x > cmax[d]) ? cmax[d] : x;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        phase[d] = 0; e_valid[d] = 0; e_tmo[d] = 0;
        e_delay[d] = 0; e_width[d] = 0;
      end
      pr = 1; pd = 1; have = 0; k = 0;
    end else begin
      if (have) begin
        for (int d = 0; d < 2; d++) begin
          logic   rr, dr, df, iss;
          longint el;
          rr = !pr && s_ref;
          dr = !pd && s_dly;
          df = pd && !s_dly;
          iss = 0;
          e_valid[d] = 0;
          if (phase[d] == 0) begin
            if (rr) begin
              k_ref[d] = k; to_l[d] = tnum & cmax[d];
              if (dr) begin dly_val[d] = 0; k_dly[d] = k; phase[d] = 2; end
              else phase[d] = 1;
            end
          end else if (phase[d] == 1) begin
            el = clip(k - k_ref[d], d);
            if (dr) begin dly_val[d] = el; k_dly[d] = k; phase[d] = 2; end
            else if (to_l[d] != 0 && el == to_l[d]) begin
              iss = 1; e_delay[d] = el; e_width[d] = 0; e_tmo[d] = 1;
            end
          end else begin
            el = clip(k - k_dly[d], d);
            if (df || (to_l[d] != 0 && el == to_l[d])) begin
              iss = 1; e_delay[d] = dly_val[d]; e_width[d] = el; e_tmo[d] = !df;
            end
          end
          if (iss) begin
            e_valid[d] = 1;
            phase[d] = 0;
            if (rr) begin k_ref[d] = k; to_l[d] = tnum & cmax[d]; phase[d] = 1; end
          end
        end
        pr = s_ref; pd = s_dly;
      end
      s_ref = ref_in; s_dly = dly_in; have = 1; k++;
    end
  end

  int vcnt[2] = '{0, 0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("busy[%0d]", d),  d_busy[d],  phase[d] != 0);
      chk($sformatf("valid[%0d]", d), d_valid[d], e_valid[d]);
      chk($sformatf("delay[%0d]", d), d_delay[d], e_delay[d]);
      chk($sformatf("width[%0d]", d), d_width[d], e_width[d]);
      chk($sformatf("tmo[%0d]", d),   d_tmo[d],   e_tmo[d]);
      if (d_valid[d]) vcnt[d]++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int d, input longint dl,
                     input longint wd, input longint tm);
    chk({name, " dut delay"},   d_delay[d], dl);
    chk({name, " dut width"},   d_width[d], wd);
    chk({name, " dut timeout"}, d_tmo[d],   tm);
    chk({name, " model delay"}, e_delay[d], dl);
    chk({name, " model width"}, e_width[d], wd);
  endtask

  int v0, v1;

  initial begin
    cyc(3);
    chk("reset busy",  d_busy[0],  0);
    chk("reset valid", d_valid[0], 0);
    chk("reset delay", d_delay[0], 0);
    rst_n = 1'b1;
    cyc(3);

    // 1: delay 5, width 8
    v0 = vcnt[0];
    ref_in = 1; cyc(2); ref_in = 0; cyc(3);
    dly_in = 1; cyc(8); dly_in = 0; cyc(6);
    chk("t1 one result", vcnt[0] - v0, 1);
    lit("t1", 0, 5, 8, 0);
    lit("t1 w8", 1, 5, 8, 0);

    // 2: coincident edges, one-cycle pulse
    ref_in = 1; dly_in = 1; cyc(1); dly_in = 0; cyc(1); ref_in = 0; cyc(5);
    lit("t2", 0, 0, 1, 0);

    // 3: timeout while waiting for the delayed edge
    tnum = 10;
    ref_in = 1; cyc(2); ref_in = 0; cyc(15);
    lit("t3", 0, 10, 0, 1);
    chk("t3 busy low", d_busy[0], 0);

    // 4: 300-cycle delay saturates the 8-bit counter
    tnum = 0;
    ref_in = 1; cyc(2); ref_in = 0; cyc(298);
    dly_in = 1; cyc(4); dly_in = 0; cyc(5);
    lit("t4", 0, 300, 4, 0);
    lit("t4 w8", 1, 255, 4, 0);

    // 5: extra ref rise ignored; ref rise on the result cycle restarts
    v0 = vcnt[0];
    ref_in = 1; cyc(2); ref_in = 0; cyc(2); ref_in = 1; cyc(2); ref_in = 0; cyc(3);
    dly_in = 1; cyc(3);
    dly_in = 0; ref_in = 1; cyc(2);
    chk("t5 valid", d_valid[0], 1);
    chk("t5 busy held", d_busy[0], 1);
    lit("t5a", 0, 9, 3, 0);
    ref_in = 0; cyc(2); dly_in = 1; cyc(2); dly_in = 0; cyc(5);
    chk("t5 two results", vcnt[0] - v0, 2);
    lit("t5b", 0, 4, 2, 0);

    // 6: reset during WAIT_FALL, released with ref high
    v1 = vcnt[0];
    ref_in = 1; cyc(2); dly_in = 1; cyc(3);
    rst_n = 0; #1;
    chk("t6 abort busy",  d_busy[0],  0);
    chk("t6 abort delay", d_delay[0], 0);
    dly_in = 0; cyc(3); rst_n = 1; cyc(5);
    chk("t6 busy stays low", d_busy[0], 0);
    chk("t6 no result", vcnt[0] - v1, 0);
    ref_in = 0; cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
